// File: rtl/csel_adder_pkg.sv
// Shared constants and types for the pipelined carry-select adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package csel_adder_pkg;

    // Number of carry-select segments across the operand width.
    function automatic int calc_nseg(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 0;
    endfunction

    // Number of pipeline stages, each resolving sps segments.
    function automatic int calc_nstage(input int width, input int seg, input int sps);
        return (seg > 0 && sps > 0) ? ((width / seg) / sps) : 0;
    endfunction

    // Per-stage control record: valid bit and the running carry out of the
    // highest segment resolved so far. The partial sum and the pending upper
    // operand bits travel beside it with stage-dependent widths.
    typedef struct packed {
        logic vld;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/csel_segment.sv
// One carry-select segment: two ripple adders (carry-in 0 and 1) and a select mux.
// Latency: combinational, zero cycles.
// Backpressure: none, purely combinational.
module csel_segment
    import csel_adder_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o
);

    logic [SEG:0]   c_lo;
    logic [SEG:0]   c_hi;
    logic [SEG-1:0] s_lo;
    logic [SEG-1:0] s_hi;

    // Both ripple chains evaluated speculatively, one per assumed carry-in.
    always_comb begin
        c_lo    = '0;
        c_hi    = '0;
        s_lo    = '0;
        s_hi    = '0;
        c_hi[0] = 1'b1;
        for (int i = 0; i < SEG; i++) begin
            s_lo[i]   = a_i[i] ^ b_i[i] ^ c_lo[i];
            c_lo[i+1] = (a_i[i] & b_i[i]) | (c_lo[i] & (a_i[i] ^ b_i[i]));
            s_hi[i]   = a_i[i] ^ b_i[i] ^ c_hi[i];
            c_hi[i+1] = (a_i[i] & b_i[i]) | (c_hi[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign sum_o  = c_i ? s_hi : s_lo;
    assign cout_o = c_i ? c_hi[SEG] : c_lo[SEG];

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select add/subtract; each stage resolves SPS segments of SEG bits.
// Latency: P = WIDTH/SEG/SPS cycles from acceptance to out_valid.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready mirrors the advance enable.
module csel_adder_pipe
    import csel_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG   = 8,
    parameter int SPS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = calc_nseg(WIDTH, SEG);
    localparam int P    = calc_nstage(WIDTH, SEG, SPS);
    localparam int SPW  = SEG * SPS;

    if (SEG < 2) begin : g_err_seg
        $error("csel_adder_pipe: SEG must be at least 2");
    end
    if (WIDTH % SEG != 0) begin : g_err_width
        $error("csel_adder_pipe: WIDTH must be a multiple of SEG");
    end
    if (SPS < 1 || NSEG % SPS != 0) begin : g_err_sps
        $error("csel_adder_pipe: WIDTH/SEG must be a multiple of SPS");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // A stalled result at the output freezes every stage, including the input.
    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv;

    // Subtraction is a + ~b + 1; the external carry-in only matters for add.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    for (genvar k = 0; k < P; k++) begin : g_stage
        localparam int LO = k * SPW;
        localparam int HI = LO + SPW;

        logic             vld_in;
        logic             c_in;
        logic [WIDTH-1:LO] a_src;
        logic [WIDTH-1:LO] b_src;
        logic [HI-1:0]     psum_d;
        logic [SPS:0]      c_chain;

        if (k == 0) begin : g_head
            assign vld_in = in_valid;
            assign c_in   = c0;
            assign a_src  = a;
            assign b_src  = b_eff;
        end else begin : g_body
            assign vld_in            = g_stage[k-1].g_mid.ctl_q.vld;
            assign c_in              = g_stage[k-1].g_mid.ctl_q.carry;
            assign a_src             = g_stage[k-1].g_mid.pa_q;
            assign b_src             = g_stage[k-1].g_mid.pb_q;
            assign psum_d[LO-1:0]    = g_stage[k-1].g_mid.psum_q;
        end

        assign c_chain[0] = c_in;

        for (genvar s = 0; s < SPS; s++) begin : g_seg
            csel_segment #(
                .SEG (SEG)
            ) u_seg (
                .a_i    (a_src[LO+s*SEG +: SEG]),
                .b_i    (b_src[LO+s*SEG +: SEG]),
                .c_i    (c_chain[s]),
                .sum_o  (psum_d[LO+s*SEG +: SEG]),
                .cout_o (c_chain[s+1])
            );
        end

        if (k < P - 1) begin : g_mid
            stage_ctl_t         ctl_d;
            stage_ctl_t         ctl_q;
            logic [HI-1:0]      psum_q;
            logic [WIDTH-1:HI]  pa_q;
            logic [WIDTH-1:HI]  pb_q;

            assign ctl_d = '{vld: vld_in, carry: c_chain[SPS]};

            // Capture resolved low bits, the carry out of them, and the operand bits still to add.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ctl_q  <= '0;
                    psum_q <= '0;
                    pa_q   <= '0;
                    pb_q   <= '0;
                end else if (adv) begin
                    ctl_q  <= ctl_d;
                    psum_q <= psum_d;
                    pa_q   <= a_src[WIDTH-1:HI];
                    pb_q   <= b_src[WIDTH-1:HI];
                end
            end
        end else begin : g_last
            logic ovf_d;

            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            assign ovf_d = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ psum_d[WIDTH-1] ^ c_chain[SPS];

            // Final stage doubles as the registered output, held while stalled.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    cout_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (adv) begin
                    out_valid_q <= vld_in;
                    sum_q       <= psum_d;
                    cout_q      <= c_chain[SPS];
                    ovf_q       <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: directed vectors on the default build, random ops on a P=1 build.
// Latency: n/a.
// Backpressure: exercised by a stall window on the default build.
module tb_csel_adder_pipe;

    logic        clk;
    logic        rst;

    logic        d64_in_valid, d64_in_ready, d64_cin, d64_sub;
    logic        d64_out_valid, d64_out_ready, d64_cout, d64_ovf;
    logic [63:0] d64_a, d64_b, d64_sum;

    logic        d32_in_valid, d32_in_ready, d32_cin, d32_sub;
    logic        d32_out_valid, d32_out_ready, d32_cout, d32_ovf;
    logic [31:0] d32_a, d32_b, d32_sum;

    int n_chk;
    int n_fail;

    csel_adder_pipe u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d64_in_valid),
        .in_ready  (d64_in_ready),
        .a         (d64_a),
        .b         (d64_b),
        .cin       (d64_cin),
        .sub       (d64_sub),
        .out_valid (d64_out_valid),
        .out_ready (d64_out_ready),
        .sum       (d64_sum),
        .cout      (d64_cout),
        .ovf       (d64_ovf)
    );

    csel_adder_pipe #(
        .WIDTH (32),
        .SEG   (4),
        .SPS   (8)
    ) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d32_in_valid),
        .in_ready  (d32_in_ready),
        .a         (d32_a),
        .b         (d32_b),
        .cin       (d32_cin),
        .sub       (d32_sub),
        .out_valid (d32_out_valid),
        .out_ready (d32_out_ready),
        .sum       (d32_sum),
        .cout      (d32_cout),
        .ovf       (d32_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum}; overflow from operand/result signs.
    function automatic logic [65:0] ref64(input logic [63:0] av, input logic [63:0] bv,
                                          input logic cv, input logic sv);
        logic [63:0] be;
        logic        c_in;
        logic [64:0] full;
        logic        ov;
        be   = sv ? ~bv : bv;
        c_in = sv ? 1'b1 : cv;
        full = {1'b0, av} + {1'b0, be} + {64'd0, c_in};
        ov   = (av[63] == be[63]) && (full[63] != av[63]);
        return {ov, full[64], full[63:0]};
    endfunction

    function automatic logic [33:0] ref32(input logic [31:0] av, input logic [31:0] bv,
                                          input logic cv, input logic sv);
        logic [31:0] be;
        logic        c_in;
        logic [32:0] full;
        logic        ov;
        be   = sv ? ~bv : bv;
        c_in = sv ? 1'b1 : cv;
        full = {1'b0, av} + {1'b0, be} + {32'd0, c_in};
        ov   = (av[31] == be[31]) && (full[31] != av[31]);
        return {ov, full[32], full[31:0]};
    endfunction

    task automatic set64(input logic [63:0] av, input logic [63:0] bv, input logic cv, input logic sv);
        d64_a   = av;
        d64_b   = bv;
        d64_cin = cv;
        d64_sub = sv;
    endtask

    // One isolated op on the 64-bit build; entered and left at posedge+1.
    task automatic run_single(input string tag, input logic [63:0] av, input logic [63:0] bv,
                              input logic cv, input logic sv, input logic [63:0] es,
                              input logic ec, input logic eo);
        int lat;
        set64(av, bv, cv, sv);
        d64_in_valid  = 1'b1;
        d64_out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, d64_in_ready, 1);
        @(posedge clk);
        #1;
        d64_in_valid = 1'b0;
        lat = 1;
        while (!d64_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_sum"}, d64_sum, es);
        chk({tag, "_cout"}, d64_cout, ec);
        chk({tag, "_ovf"}, d64_ovf, eo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [65:0] exp_q[$];
        logic [33:0] exp32;
        logic        exp32_v;
        int          idx;
        int          got;
        int          cyc;
        int          stale;
        logic        stall;

        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        d64_in_valid  = 1'b0;
        d64_out_ready = 1'b0;
        set64(64'd0, 64'd0, 1'b0, 1'b0);
        d32_in_valid  = 1'b0;
        d32_out_ready = 1'b1;
        d32_a = 32'd0;
        d32_b = 32'd0;
        d32_cin = 1'b0;
        d32_sub = 1'b0;

        // Reset state, with out_ready low to show in_ready is still 1.
        #3;
        chk("rst_out_valid", d64_out_valid, 0);
        chk("rst_sum", d64_sum, 0);
        chk("rst_cout_ovf", {d64_cout, d64_ovf}, 0);
        chk("rst_in_ready", d64_in_ready, 1);
        chk("rst_d32_out_valid", d32_out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed vectors with hand-computed results.
        run_single("allones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                   64'h0, 1'b1, 1'b0);
        run_single("maxpos_inc", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_single("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_single("sub_5_7_cin", 64'd5, 64'd7, 1'b1, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_single("sub_7_5", 64'd7, 64'd5, 1'b0, 1'b1,
                   64'd2, 1'b1, 1'b0);
        run_single("minneg_add", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                   64'h0, 1'b1, 1'b1);
        run_single("minneg_sub1", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_single("carry_stage", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                   64'h0000_0001_0000_0000, 1'b0, 1'b0);

        // Eight back-to-back ops, output stalled in cycles 5..7.
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 40) begin
            stall = (cyc >= 5 && cyc <= 7);
            d64_out_ready = !stall;
            if (idx < 8) begin
                set64({32'hDEAD_0000 | idx, 32'hFFFF_FFF0 + idx}, 64'h0000_0001_0000_0011 * (idx + 1),
                      idx[1], idx[0]);
                d64_in_valid = 1'b1;
            end else begin
                d64_in_valid = 1'b0;
            end
            #1;
            chk("stall_in_ready", d64_in_ready, !stall);
            if (stall) chk("stall_hold_vld", d64_out_valid, 1);
            if (d64_out_valid) begin
                chk("stall_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("stall_res", {d64_ovf, d64_cout, d64_sum}, exp_q[0]);
                    if (d64_out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (d64_in_valid && d64_in_ready) begin
                exp_q.push_back(ref64(d64_a, d64_b, d64_cin, d64_sub));
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        d64_in_valid  = 1'b0;
        d64_out_ready = 1'b1;
        chk("stall_got", got, 8);
        chk("stall_sent", idx, 8);

        // Reset with three ops in flight (oldest already at the output).
        for (int i = 0; i < 3; i++) begin
            set64(64'h1234 + i, 64'h1111, 1'b0, 1'b0);
            d64_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        d64_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_vld", d64_out_valid, 1);
        chk("pre_rst_sum", d64_sum, 64'h2345);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", d64_out_valid, 0);
        chk("mid_rst_sum", d64_sum, 0);
        chk("mid_rst_cout_ovf", {d64_cout, d64_ovf}, 0);
        chk("mid_rst_rdy", d64_in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_single("post_rst", 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0,
                   64'h0, 1'b1, 1'b0);
        stale = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (d64_out_valid) stale++;
        end
        chk("post_rst_stale", stale, 0);

        // P=1 build: random ops, one-cycle latency, reference model.
        chk("d32_rdy", d32_in_ready, 1);
        for (int n = 0; n < 10000; n++) begin
            d32_in_valid = ($urandom_range(0, 7) != 0);
            d32_a   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            d32_b   = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
            d32_cin = $urandom_range(0, 1);
            d32_sub = $urandom_range(0, 1);
            exp32_v = d32_in_valid;
            exp32   = ref32(d32_a, d32_b, d32_cin, d32_sub);
            @(posedge clk);
            #1;
            chk("rnd_vld", d32_out_valid, exp32_v);
            if (exp32_v) chk("rnd_res", {d32_ovf, d32_cout, d32_sum}, exp32);
        end
        d32_in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
